// File: rtl/vga_pkg.sv
// Shared VGA raster constants, coordinate/colour widths and the controller state type.
package vga_pkg;

  localparam int COORD_W  = 10;
  localparam int COLOUR_W = 4;
  localparam int COORD_LIMIT = 2 ** COORD_W;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;

  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COLOUR_W-1:0] colour_t;

  typedef enum logic {
    ST_PARK = 1'b0,
    ST_RUN  = 1'b1
  } vga_state_e;

  function automatic int vgaTotal(input int visible, input int front, input int sync, input int back);
    return visible + front + sync + back;
  endfunction

  localparam int H_TOTAL_DEF = vgaTotal(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = vgaTotal(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);

endpackage

// File: rtl/vga_sync_controller_if.sv
// Raster bundle between the sync controller (master) and the colour stage (slave).
interface vga_sync_controller_if;
  import vga_pkg::*;

  logic   enable;
  logic   pixel_tick;
  coord_t pixel_x;
  coord_t pixel_y;
  logic   display_on;
  logic   hsync;
  logic   vsync;
  logic   line_start;
  logic   frame_start;

  modport master (
    input  enable,
    output pixel_tick, pixel_x, pixel_y, display_on, hsync, vsync, line_start, frame_start
  );

  modport slave (
    output enable,
    input  pixel_tick, pixel_x, pixel_y, display_on, hsync, vsync, line_start, frame_start
  );

endinterface

// File: rtl/vga_sync_controller_pixel_tick.sv
// Pixel-rate qualifier: divide-by-2 phase when VGA_PIXEL_DIV2_EN is defined, otherwise every edge.
module vga_pixel_tick (
  input  logic clock_50,
  input  logic reset_n,
  output logic pixel_tick_o,
  output logic advance_o
);

`ifdef VGA_PIXEL_DIV2_EN
  logic phase_q;
  logic phase_d;

  assign phase_d = ~phase_q;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign pixel_tick_o = phase_q;
  assign advance_o    = phase_q;
`else
  // The visible tick flag reads 0 in reset and 1 afterwards; advancing never waits on it.
  logic tick_q;

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= 1'b1;
    end
  end

  assign pixel_tick_o = tick_q;
  assign advance_o    = 1'b1;
`endif

endmodule

// File: rtl/vga_sync_controller.sv
// VGA raster timing generator: registered coordinates, sync and framing flags for one position.
// Build option: VGA_PIXEL_DIV2_EN halves the pixel rate relative to clock_50.
module vga_sync_controller
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = H_VISIBLE_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_VISIBLE = V_VISIBLE_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF
) (
  input logic                   clock_50,
  input logic                   reset_n,
  vga_sync_controller_if.master vga
);

  localparam int H_TOTAL = vgaTotal(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = vgaTotal(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

  localparam int H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam int H_SYNC_STOP  = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam int V_SYNC_STOP  = V_SYNC_START + V_SYNC;

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

  if ((H_TOTAL > COORD_LIMIT) || (V_TOTAL > COORD_LIMIT)) begin : g_timing_check
    $error("vga_sync_controller: raster totals exceed the coordinate range");
  end

  vga_state_e state_q, state_d;
  coord_t     x_q, x_d;
  coord_t     y_q, y_d;
  logic       displayOn_q, displayOn_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       lineStart_q, lineStart_d;
  logic       frameStart_q, frameStart_d;
  logic       tickOut;
  logic       advance;

  vga_pixel_tick u_pixel_tick (
    .clock_50     (clock_50),
    .reset_n      (reset_n),
    .pixel_tick_o (tickOut),
    .advance_o    (advance)
  );

  // Parking always leaves the counters on the last position so the next advance lands on (0,0).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;

    unique case (state_q)
      ST_PARK: begin
        if (vga.enable && advance) begin
          state_d = ST_RUN;
          x_d     = '0;
          y_d     = '0;
        end
      end
      ST_RUN: begin
        if (!vga.enable) begin
          state_d = ST_PARK;
          x_d     = H_LAST;
          y_d     = V_LAST;
        end else if (advance) begin
          if (x_q == H_LAST) begin
            x_d = '0;
            y_d = (y_q == V_LAST) ? '0 : y_q + coord_t'(1);
          end else begin
            x_d = x_q + coord_t'(1);
          end
        end
      end
      default: begin
        state_d = ST_PARK;
        x_d     = H_LAST;
        y_d     = V_LAST;
      end
    endcase

    displayOn_d  = 1'b0;
    hsync_d      = 1'b1;
    vsync_d      = 1'b1;
    lineStart_d  = 1'b0;
    frameStart_d = 1'b0;

    // Flags track the position being loaded, keeping them aligned with the coordinates.
    if (state_d == ST_RUN) begin
      displayOn_d  = (int'(x_d) < H_VISIBLE) && (int'(y_d) < V_VISIBLE);
      hsync_d      = !((int'(x_d) >= H_SYNC_START) && (int'(x_d) < H_SYNC_STOP));
      vsync_d      = !((int'(y_d) >= V_SYNC_START) && (int'(y_d) < V_SYNC_STOP));
      lineStart_d  = (x_d == '0);
      frameStart_d = (x_d == '0) && (y_d == '0);
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_PARK;
      x_q          <= H_LAST;
      y_q          <= V_LAST;
      displayOn_q  <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      lineStart_q  <= 1'b0;
      frameStart_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      displayOn_q  <= displayOn_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      lineStart_q  <= lineStart_d;
      frameStart_q <= frameStart_d;
    end
  end

  assign vga.pixel_tick  = tickOut;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.display_on  = displayOn_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.line_start  = lineStart_q;
  assign vga.frame_start = frameStart_q;

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench: default-timing instance for reset/line behaviour, a shrunken instance for whole frames.
module tb_vga_sync_controller;
  import vga_pkg::*;

`ifdef VGA_PIXEL_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif
  localparam logic EXP_TICK = (DIV == 1);
  localparam int A_HT = 800;
  localparam int A_VT = 525;
  localparam int B_HT = 32;
  localparam int B_VT = 17;

  typedef struct {
    int         x;
    int         y;
    logic [4:0] flags;
  } vecT;

  logic clock_50 = 1'b0;
  logic reset_n;
  logic enable;
  int   testsRun = 0;
  int   testsFailed = 0;
  int   idxA;
  int   idxB;
  vecT  tabA[10];
  vecT  tabB[15];
  vecT  parkA;
  vecT  parkB;

  always #5 clock_50 = ~clock_50;

  vga_sync_controller_if vgaA ();
  vga_sync_controller_if vgaB ();

  assign vgaA.enable = enable;
  assign vgaB.enable = enable;

  vga_sync_controller dutA (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .vga      (vgaA.master)
  );

  vga_sync_controller #(
    .H_VISIBLE (20), .H_FRONT (4), .H_SYNC (6), .H_BACK (2),
    .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3)
  ) dutB (
    .clock_50 (clock_50),
    .reset_n  (reset_n),
    .vga      (vgaB.master)
  );

  function automatic vecT mkVec(input int x, input int y, input logic [4:0] flags);
    vecT v;
    v.x = x;
    v.y = y;
    v.flags = flags;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Flags are packed {display_on, hsync, vsync, line_start, frame_start}.
  task automatic checkA(input string tag, input vecT v);
    checkOutput({tag, ".x"}, 32'(vgaA.pixel_x), v.x);
    checkOutput({tag, ".y"}, 32'(vgaA.pixel_y), v.y);
    checkOutput({tag, ".flags"},
                32'({vgaA.display_on, vgaA.hsync, vgaA.vsync, vgaA.line_start, vgaA.frame_start}),
                32'(v.flags));
  endtask

  task automatic checkB(input string tag, input vecT v);
    checkOutput({tag, ".x"}, 32'(vgaB.pixel_x), v.x);
    checkOutput({tag, ".y"}, 32'(vgaB.pixel_y), v.y);
    checkOutput({tag, ".flags"},
                32'({vgaB.display_on, vgaB.hsync, vgaB.vsync, vgaB.line_start, vgaB.frame_start}),
                32'(v.flags));
  endtask

  task automatic applyStimulus(input int steps);
    for (int s = 0; s < steps; s++) begin
      repeat (DIV) @(posedge clock_50);
      #1;
      idxA = (idxA + 1) % (A_HT * A_VT);
      idxB = (idxB + 1) % (B_HT * B_VT);
    end
  endtask

  task automatic walkA(input int x, input int y);
    applyStimulus((y * A_HT + x - idxA + A_HT * A_VT) % (A_HT * A_VT));
  endtask

  task automatic walkB(input int x, input int y);
    applyStimulus((y * B_HT + x - idxB + B_HT * B_VT) % (B_HT * B_VT));
  endtask

  task automatic waitRestart(input string tag);
    logic seen;
    seen = 1'b0;
    for (int e = 0; e < 4 && !seen; e++) begin
      @(posedge clock_50);
      #1;
      seen = vgaA.frame_start;
    end
    checkOutput({tag, ".restartSeen"}, 32'(seen), 1);
    idxA = 0;
    idxB = 0;
  endtask

  initial begin
    int hsLow, vsLow, dispCnt, lsCnt, fsCnt, fsAt;

    parkA = mkVec(799, 524, 5'b01100);
    parkB = mkVec(31, 16, 5'b01100);

    tabA[0] = mkVec(1,   0, 5'b11100);
    tabA[1] = mkVec(639, 0, 5'b11100);
    tabA[2] = mkVec(640, 0, 5'b01100);
    tabA[3] = mkVec(655, 0, 5'b01100);
    tabA[4] = mkVec(656, 0, 5'b00100);
    tabA[5] = mkVec(751, 0, 5'b00100);
    tabA[6] = mkVec(752, 0, 5'b01100);
    tabA[7] = mkVec(799, 0, 5'b01100);
    tabA[8] = mkVec(0,   1, 5'b11110);
    tabA[9] = mkVec(5,   2, 5'b11100);

    tabB[0]  = mkVec(19, 0,  5'b11100);
    tabB[1]  = mkVec(20, 0,  5'b01100);
    tabB[2]  = mkVec(23, 0,  5'b01100);
    tabB[3]  = mkVec(24, 0,  5'b00100);
    tabB[4]  = mkVec(29, 0,  5'b00100);
    tabB[5]  = mkVec(30, 0,  5'b01100);
    tabB[6]  = mkVec(0,  1,  5'b11110);
    tabB[7]  = mkVec(19, 9,  5'b11100);
    tabB[8]  = mkVec(0,  10, 5'b01110);
    tabB[9]  = mkVec(5,  11, 5'b01100);
    tabB[10] = mkVec(5,  12, 5'b01000);
    tabB[11] = mkVec(31, 13, 5'b01000);
    tabB[12] = mkVec(0,  14, 5'b01110);
    tabB[13] = mkVec(31, 16, 5'b01100);
    tabB[14] = mkVec(0,  0,  5'b11111);

    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (3) @(posedge clock_50);
    #1;
    checkA("rstA", parkA);
    checkB("rstB", parkB);
    checkOutput("rst.tickA", 32'(vgaA.pixel_tick), 0);

    enable = 1'b1;
    @(negedge clock_50);
    reset_n = 1'b1;
`ifdef VGA_PIXEL_DIV2_EN
    @(posedge clock_50);
    #1;
    checkOutput("edge1.tick", 32'(vgaA.pixel_tick), 1);
    checkA("edge1", parkA);
`endif
    @(posedge clock_50);
    #1;
    checkA("firstAdv", mkVec(0, 0, 5'b11111));
    checkB("firstAdvB", mkVec(0, 0, 5'b11111));
    checkOutput("firstAdv.tick", 32'(vgaA.pixel_tick), 32'(EXP_TICK));
    idxA = 0;
    idxB = 0;
`ifdef VGA_PIXEL_DIV2_EN
    @(posedge clock_50);
    #1;
    checkA("holdFs", mkVec(0, 0, 5'b11111));
    @(posedge clock_50);
    #1;
    idxA = 1;
    idxB = 1;
    checkOutput("secondAdv.x", 32'(vgaA.pixel_x), 1);
`endif

    for (int i = 0; i < 10; i++) begin
      walkA(tabA[i].x, tabA[i].y);
      checkA($sformatf("tabA[%0d]", i), tabA[i]);
    end

    walkA(0, 3);
    hsLow = 0; dispCnt = 0; lsCnt = 0; fsCnt = 0;
    for (int s = 0; s < A_HT; s++) begin
      applyStimulus(1);
      hsLow   += int'(!vgaA.hsync);
      dispCnt += int'(vgaA.display_on);
      lsCnt   += int'(vgaA.line_start);
      fsCnt   += int'(vgaA.frame_start);
    end
    checkA("lineEnd", mkVec(0, 4, 5'b11110));
    checkOutput("line.hsLow", hsLow, 96);
    checkOutput("line.disp", dispCnt, 640);
    checkOutput("line.ls", lsCnt, 1);
    checkOutput("line.fs", fsCnt, 0);
    checkOutput("line.tick", 32'(vgaA.pixel_tick), 32'(EXP_TICK));

    // Enable drops mid-line: the very next edge must park, tick or not.
    walkA(320, 4);
    checkA("preDrop", mkVec(320, 4, 5'b11100));
    enable = 1'b0;
    @(posedge clock_50);
    #1;
    checkA("drop", parkA);
    checkB("dropB", parkB);
    repeat (3) @(posedge clock_50);
    #1;
    checkA("parkHold", parkA);
    enable = 1'b1;
    waitRestart("reenA");
    checkA("reenA", mkVec(0, 0, 5'b11111));
    checkB("reenB", mkVec(0, 0, 5'b11111));

    for (int i = 0; i < 15; i++) begin
      walkB(tabB[i].x, tabB[i].y);
      checkB($sformatf("tabB[%0d]", i), tabB[i]);
    end

    hsLow = 0; vsLow = 0; dispCnt = 0; lsCnt = 0; fsCnt = 0; fsAt = -1;
    for (int s = 1; s <= B_HT * B_VT; s++) begin
      applyStimulus(1);
      hsLow   += int'(!vgaB.hsync);
      vsLow   += int'(!vgaB.vsync);
      dispCnt += int'(vgaB.display_on);
      lsCnt   += int'(vgaB.line_start);
      fsCnt   += int'(vgaB.frame_start);
      if (vgaB.frame_start && fsAt < 0) fsAt = s;
    end
    checkOutput("frame.fsPeriod", fsAt, B_HT * B_VT);
    checkOutput("frame.fsCount", fsCnt, 1);
    checkOutput("frame.lsCount", lsCnt, B_VT);
    checkOutput("frame.disp", dispCnt, 200);
    checkOutput("frame.hsLow", hsLow, 6 * B_VT);
    checkOutput("frame.vsLow", vsLow, 2 * B_HT);

    // Enable falls on the same edge that would wrap to (0,0): park must win.
    walkB(31, 16);
`ifdef VGA_PIXEL_DIV2_EN
    @(posedge clock_50);
    #1;
`endif
    enable = 1'b0;
    @(posedge clock_50);
    #1;
    checkB("wrapDrop", parkB);

    enable = 1'b1;
    waitRestart("reenB2");
    walkB(28, 14);
    checkB("preReset", mkVec(28, 14, 5'b00100));
    #3;
    reset_n = 1'b0;
    #1;
    checkB("asyncRst", parkB);
    checkOutput("asyncRst.tick", 32'(vgaB.pixel_tick), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
